// File: rtl/mem_pkg.sv
// Shared types and helpers for the line-burst memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } mem_state_t;

  // Width of a counter that must hold values up to n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: one byte-enabled write port, one registered read port, no reset.
module mem_array #(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [ADDR_SIZE-1:0]   i_waddr,
  input  logic [DATA_SIZE-1:0]   i_wdata,
  input  logic [DATA_SIZE/8-1:0] i_wbe,
  input  logic                   i_re,
  input  logic [ADDR_SIZE-1:0]   i_raddr,
  output logic [DATA_SIZE-1:0]   o_rdata
);

  localparam int unsigned Depth = 2 ** ADDR_SIZE;

  logic [DATA_SIZE-1:0] r_mem [Depth];
  logic [DATA_SIZE-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_SIZE / 8; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_line_ctrl.sv
// Line-burst controller: fixed-latency read bursts and flow-controlled, byte-enabled
// write bursts over a synchronous-read storage array.
module mem_line_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_SIZE      = 10,
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic [DATA_SIZE/8-1:0] wr_be,
  output logic                   rd_valid,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   rd_last,
  output logic                   wr_done,
  output logic                   busy
);

  localparam int unsigned CntW  = clog2_min1(WORDS_PER_LINE);
  localparam int unsigned WaitW = clog2_min1(LATENCY);
  localparam logic [CntW-1:0]      BeatLast = CntW'(WORDS_PER_LINE - 1);
  localparam logic [WaitW-1:0]     WaitLast = WaitW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [ADDR_SIZE-1:0] LineMask = ~ADDR_SIZE'(WORDS_PER_LINE - 1);

  mem_state_t           r_state, w_state_d;
  logic [ADDR_SIZE-1:0] r_base, w_base_d;
  logic [CntW-1:0]      r_beat, w_beat_d, w_beat_inc;
  logic [WaitW-1:0]     r_wait, w_wait_d;
  logic                 r_wr_done, w_wr_done_d;
  logic                 r_rd_seen;
  logic                 w_we, w_re;
  logic [ADDR_SIZE-1:0] w_raddr, w_waddr;
  logic [DATA_SIZE-1:0] w_rdata;

  assign w_beat_inc = r_beat + CntW'(1);
  // Base has its beat bits cleared, so OR-ing the beat in can never carry into the line.
  assign w_waddr    = r_base | ADDR_SIZE'(r_beat);

  always_comb begin
    w_state_d   = r_state;
    w_base_d    = r_base;
    w_beat_d    = r_beat;
    w_wait_d    = r_wait;
    w_wr_done_d = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_raddr     = r_base;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_base_d = req_addr & LineMask;
          w_beat_d = '0;
          w_wait_d = '0;
          if (req_wr) begin
            w_state_d = WR_BURST;
          end else if (LATENCY == 1) begin
            w_state_d = RD_BURST;
            w_re      = 1'b1;
            w_raddr   = req_addr & LineMask;
          end else begin
            w_state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Beat 0 is fetched in the last wait cycle so it is on the port when the burst starts.
        if (r_wait == WaitLast) begin
          w_state_d = RD_BURST;
          w_re      = 1'b1;
        end else begin
          w_wait_d = r_wait + WaitW'(1);
        end
      end
      RD_BURST: begin
        if (r_beat == BeatLast) begin
          w_state_d = IDLE;
        end else begin
          w_beat_d = w_beat_inc;
          w_re     = 1'b1;
          w_raddr  = r_base | ADDR_SIZE'(w_beat_inc);
        end
      end
      WR_BURST: begin
        if (wr_valid) begin
          w_we = 1'b1;
          if (r_beat == BeatLast) begin
            w_state_d   = IDLE;
            w_wr_done_d = 1'b1;
          end else begin
            w_beat_d = w_beat_inc;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_beat    <= '0;
      r_wait    <= '0;
      r_wr_done <= 1'b0;
      r_rd_seen <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_base    <= w_base_d;
      r_beat    <= w_beat_d;
      r_wait    <= w_wait_d;
      r_wr_done <= w_wr_done_d;
      if (w_re) r_rd_seen <= 1'b1;
    end
  end

  mem_array #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) u_array (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(wr_data),
    .i_wbe  (wr_be),
    .i_re   (w_re),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  assign req_ready = (r_state == IDLE);
  assign busy      = ~req_ready;
  assign wr_ready  = (r_state == WR_BURST);
  assign rd_valid  = (r_state == RD_BURST);
  assign rd_last   = rd_valid & (r_beat == BeatLast);
  assign wr_done   = r_wr_done;
  // The array's read register is not reset; mask it until a read has actually been issued.
  assign rd_data   = r_rd_seen ? w_rdata : '0;

endmodule
